matrix_alu_seq: RTL and testbench

- Parametrised, multi-cycle successor to the bus-mapped matrix ALU.
- Sits on the execution-engine bus and claims one 4 KB address window.
- Accepts two NxN operand matrices of W-bit elements and an opcode, then computes one element (or one multiply-accumulate) per clock under a start/busy/done state machine.
- Serves result and status back over the shared read bus.

---
 rtl/matrix_alu_seq.sv | 236 +++++++++++++++++++++++
 tb/tb_matrix_alu_seq.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/matrix_alu_seq.sv
// matrix_alu_seq: multi-cycle NxN matrix ALU on the execution-engine bus.
// It claims the 4 KB window where address[15:12] == BLOCK_ID. Two operand
// matrices and an opcode are written over the bus. The block then computes
// one result element, or one multiply-accumulate, per clock. Status and the
// result matrix are read back over the shared read bus.
//
// Ports:
//   Clk           rising-edge system clock
//   nReset        synchronous active-low reset
//   nRead         active-low read strobe
//   nWrite        active-low write strobe (wins over a simultaneous read)
//   address       [15:12] block select, [11:0] register offset
//   ExeDataOut    write data, N*N W-bit elements, row-major
//   MatrixDataOut registered read data
//   Busy          high while a computation is running
module matrix_alu_seq #(
  parameter int unsigned N        = 4,
  parameter int unsigned W        = 16,
  parameter logic [3:0]  BLOCK_ID = 4'h2,
  localparam int unsigned BUS_W   = N*N*W
) (
  input  logic             Clk,
  input  logic             nReset,
  input  logic             nRead,
  input  logic             nWrite,
  input  logic [15:0]      address,
  input  logic [BUS_W-1:0] ExeDataOut,
  output logic [BUS_W-1:0] MatrixDataOut,
  output logic             Busy
);

  localparam int unsigned IW = $clog2(N);
  localparam int unsigned EW = 2*IW;
  localparam int unsigned BW = $clog2(BUS_W);

  localparam logic [11:0] OFF_SRC1   = 12'h000;
  localparam logic [11:0] OFF_SRC2   = 12'h001;
  localparam logic [11:0] OFF_SI     = 12'h002;
  localparam logic [11:0] OFF_STATUS = 12'h003;
  localparam logic [11:0] OFF_RESULT = 12'h004;

  typedef enum logic {S_IDLE, S_RUN} state_e;

  typedef enum logic [7:0] {
    OP_MMULT      = 8'h00,
    OP_MMULT2A    = 8'h01,
    OP_MMULT2B    = 8'h02,
    OP_MADD       = 8'h03,
    OP_MSUB       = 8'h04,
    OP_MTRANSPOSE = 8'h05,
    OP_MSCALE     = 8'h06,
    OP_MSCALEIMM  = 8'h07
  } op_e;

  // Operands and result are kept packed, in the same layout as the bus.
  logic [BUS_W-1:0] r_ms1, r_ms2, r_res;
  logic [W-1:0]     r_imm;
  logic [7:0]       r_opcode;
  state_e           r_state, w_state_next;
  logic             r_done, r_err;
  logic [IW-1:0]    r_i, r_j, r_k;
  logic [W-1:0]     r_acc;

  logic          w_hit, w_wr, w_rd, w_busy, w_op_valid, w_start, w_last;
  logic [11:0]   w_off;
  op_e           w_op;
  logic [IW-1:0] w_imax, w_jmax, w_kmax;
  logic          w_dense;
  logic [EW-1:0] w_e, w_et, w_ea, w_eb, w_ew;
  logic [W-1:0]  w_prod, w_mac_sum, w_value;

  function automatic logic [EW-1:0] f_idx(input logic [IW-1:0] row,
                                          input logic [IW-1:0] col,
                                          input int unsigned stride);
    f_idx = EW'(row) * EW'(stride) + EW'(col);
  endfunction

  function automatic logic [W-1:0] f_get(input logic [BUS_W-1:0] v,
                                         input logic [EW-1:0] e);
    f_get = v[BW'(e) * BW'(W) +: W];
  endfunction

  assign w_hit      = (address[15:12] == BLOCK_ID);
  assign w_off      = address[11:0];
  assign w_wr       = w_hit && !nWrite;
  assign w_rd       = w_hit && !nRead && nWrite;
  assign w_busy     = (r_state == S_RUN);
  assign w_op_valid = (ExeDataOut[7:0] <= 8'h07);
  assign w_start    = w_wr && (w_off == OFF_SI) && !w_busy && w_op_valid;
  assign w_op       = op_e'(r_opcode);

  // Loop bounds per opcode. The element-wise ops use a single k step.
  always_comb begin
    w_imax  = IW'(N-1);
    w_jmax  = IW'(N-1);
    w_kmax  = '0;
    w_dense = 1'b0;
    case (w_op)
      OP_MMULT:   w_kmax = IW'(N-1);
      OP_MMULT2A: w_kmax = IW'(N/2-1);
      OP_MMULT2B: begin
        w_imax  = IW'(N/2-1);
        w_jmax  = IW'(N/2-1);
        w_kmax  = IW'(N-1);
        w_dense = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_last = (r_i == w_imax) && (r_j == w_jmax) && (r_k == w_kmax);

  assign w_e  = f_idx(r_i, r_j, N);
  assign w_et = f_idx(r_j, r_i, N);
  assign w_ea = f_idx(r_i, r_k, N);
  assign w_eb = f_idx(r_k, r_j, N);
  // MMULT2B packs its (N/2)x(N/2) result densely at the low end.
  assign w_ew = w_dense ? f_idx(r_i, r_j, N/2) : w_e;

  assign w_prod    = f_get(r_ms1, w_ea) * f_get(r_ms2, w_eb);
  assign w_mac_sum = r_acc + w_prod;

  always_comb begin
    w_value = w_mac_sum;
    case (w_op)
      OP_MADD:       w_value = f_get(r_ms1, w_e) + f_get(r_ms2, w_e);
      OP_MSUB:       w_value = f_get(r_ms1, w_e) - f_get(r_ms2, w_e);
      OP_MTRANSPOSE: w_value = f_get(r_ms1, w_et);
      OP_MSCALE:     w_value = f_get(r_ms1, w_e) * r_ms2[W-1:0];
      OP_MSCALEIMM:  w_value = f_get(r_ms1, w_e) * r_imm;
      default: ;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_next = S_RUN;
      S_RUN:   if (w_last)  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!nReset) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_ff @(posedge Clk) begin
    if (!nReset) begin
      r_ms1         <= '0;
      r_ms2         <= '0;
      r_res         <= '0;
      r_imm         <= '0;
      r_opcode      <= '0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_i           <= '0;
      r_j           <= '0;
      r_k           <= '0;
      r_acc         <= '0;
      Busy          <= 1'b0;
      MatrixDataOut <= '0;
    end else begin
      Busy <= (w_state_next == S_RUN);

      if (w_wr) begin
        case (w_off)
          OFF_SRC1: begin
            if (w_busy) r_err <= 1'b1;
            else        r_ms1 <= ExeDataOut;
          end
          OFF_SRC2: begin
            if (w_busy) r_err <= 1'b1;
            else begin
              r_ms2 <= ExeDataOut;
              r_imm <= ExeDataOut[W-1:0];
            end
          end
          OFF_SI: begin
            if (w_busy) r_err <= 1'b1;
            else begin
              r_opcode <= ExeDataOut[7:0];
              if (w_op_valid) begin
                r_done <= 1'b0;
                r_err  <= 1'b0;
                r_res  <= '0;
                r_i    <= '0;
                r_j    <= '0;
                r_k    <= '0;
                r_acc  <= '0;
              end else begin
                r_err  <= 1'b1;
                r_done <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end

      // One step per cycle, k innermost. The accumulator only lives across
      // k; the element is committed on the last k step.
      if (w_busy) begin
        if (r_k == w_kmax) begin
          r_res[BW'(w_ew) * BW'(W) +: W] <= w_value;
          r_acc <= '0;
          r_k   <= '0;
          if (r_j == w_jmax) begin
            r_j <= '0;
            if (r_i == w_imax) begin
              r_i    <= '0;
              r_done <= 1'b1;
            end else begin
              r_i <= r_i + 1'b1;
            end
          end else begin
            r_j <= r_j + 1'b1;
          end
        end else begin
          r_acc <= w_mac_sum;
          r_k   <= r_k + 1'b1;
        end
      end

      if (w_rd) begin
        case (w_off)
          OFF_STATUS: MatrixDataOut <= BUS_W'({r_err, r_done, Busy});
          OFF_RESULT: MatrixDataOut <= r_res;
          default:    MatrixDataOut <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_matrix_alu_seq.sv
// Directed bench for matrix_alu_seq. Reads push their expected value into a
// queue. A monitor pops the queue and compares each accepted read's data.
module tb_matrix_alu_seq;

  localparam int unsigned N     = 4;
  localparam int unsigned W     = 16;
  localparam logic [3:0]  BID   = 4'h2;
  localparam int unsigned BUS_W = N*N*W;

  logic             Clk = 1'b0;
  logic             nReset, nRead, nWrite;
  logic [15:0]      address;
  logic [BUS_W-1:0] ExeDataOut, MatrixDataOut;
  logic             Busy;

  matrix_alu_seq #(.N(N), .W(W), .BLOCK_ID(BID)) dut (
    .Clk(Clk), .nReset(nReset), .nRead(nRead), .nWrite(nWrite),
    .address(address), .ExeDataOut(ExeDataOut),
    .MatrixDataOut(MatrixDataOut), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  typedef struct { string name; logic [BUS_W-1:0] val; } exp_t;
  typedef logic [W-1:0] mat_t [N*N];

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  mat_t m1, m2, mr;

  task automatic check(input string nm, input logic [BUS_W-1:0] act,
                       input logic [BUS_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [BUS_W-1:0] pk(input mat_t m);
    logic [BUS_W-1:0] v = '0;
    for (int e = 0; e < N*N; e++) v[e*W +: W] = m[e];
    return v;
  endfunction

  task automatic wr(input logic [15:0] a, input logic [BUS_W-1:0] d);
    @(negedge Clk);
    address = a; ExeDataOut = d; nWrite = 1'b0;
    @(negedge Clk);
    nWrite = 1'b1;
  endtask

  task automatic rd(input logic [11:0] off, input logic [BUS_W-1:0] ev,
                    input string nm);
    exp_t x;
    x.name = nm; x.val = ev;
    q.push_back(x);
    @(negedge Clk);
    address = {BID, off}; nRead = 1'b0;
    @(negedge Clk);
    nRead = 1'b1;
  endtask

  // Issues SI and counts the cycles Busy stays high.
  task automatic run_busy(input logic [7:0] op, input int exp_cyc,
                          input string nm);
    int n = 0;
    wr({BID, 12'h002}, BUS_W'(op));
    while (Busy === 1'b1 && n < 1000) begin
      n++;
      @(negedge Clk);
    end
    check(nm, BUS_W'(n), BUS_W'(exp_cyc));
  endtask

  // Monitor: a read accepted on a rising edge is checked at the next falling edge.
  initial begin
    bit   hit;
    exp_t x;
    forever begin
      @(posedge Clk);
      hit = nReset && !nRead && nWrite && (address[15:12] == BID);
      @(negedge Clk);
      if (hit) begin
        if (q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_read: got %h expected no read", MatrixDataOut);
        end else begin
          x = q.pop_front();
          check(x.name, MatrixDataOut, x.val);
        end
      end
    end
  end

  initial begin
    int n;
    nReset = 1'b0; nRead = 1'b1; nWrite = 1'b1;
    address = '0; ExeDataOut = '0;
    repeat (3) @(negedge Clk);
    nReset = 1'b1;
    check("busy_after_reset", BUS_W'(Busy), '0);
    rd(12'h003, '0, "status_after_reset");
    rd(12'h004, '0, "result_after_reset");

    // MADD: ones + e
    for (int e = 0; e < N*N; e++) begin m1[e] = 16'd1; m2[e] = W'(e); mr[e] = W'(e+1); end
    wr({BID, 12'h000}, pk(m1));
    wr({BID, 12'h001}, pk(m2));
    run_busy(8'h03, 16, "madd_busy");
    rd(12'h003, BUS_W'(3'b010), "madd_status");
    rd(12'h004, pk(mr), "madd_result");
    rd(12'h005, '0, "unmapped_read");

    // SI aimed at another block must not start anything.
    wr(16'h3002, '0);
    check("foreign_block_busy", BUS_W'(Busy), '0);

    // MMULT: identity * (e+5)
    for (int e = 0; e < N*N; e++) begin
      m1[e] = ((e / N) == (e % N)) ? 16'd1 : 16'd0;
      m2[e] = W'(e+5);
    end
    wr({BID, 12'h000}, pk(m1));
    wr({BID, 12'h001}, pk(m2));
    run_busy(8'h00, 64, "mmult_busy");
    rd(12'h004, pk(m2), "mmult_result");

    // MMULT2A and MMULT2B with all-ones operands
    for (int e = 0; e < N*N; e++) begin m1[e] = 16'd1; mr[e] = 16'd2; end
    wr({BID, 12'h000}, pk(m1));
    wr({BID, 12'h001}, pk(m1));
    run_busy(8'h01, 32, "mmult2a_busy");
    rd(12'h004, pk(mr), "mmult2a_result");
    run_busy(8'h02, 16, "mmult2b_busy");
    rd(12'h004, BUS_W'(64'h0004_0004_0004_0004), "mmult2b_result");

    // MADD wrap: 0xFFFF + 2
    for (int e = 0; e < N*N; e++) begin m1[e] = 16'hFFFF; m2[e] = 16'd2; mr[e] = 16'd1; end
    wr({BID, 12'h000}, pk(m1));
    wr({BID, 12'h001}, pk(m2));
    run_busy(8'h03, 16, "madd_wrap_busy");
    rd(12'h004, pk(mr), "madd_wrap_result");

    // MSUB: 1 - e, wrapping below zero
    for (int e = 0; e < N*N; e++) begin m1[e] = 16'd1; m2[e] = W'(e); mr[e] = W'(1 - e); end
    wr({BID, 12'h000}, pk(m1));
    wr({BID, 12'h001}, pk(m2));
    run_busy(8'h04, 16, "msub_busy");
    rd(12'h004, pk(mr), "msub_result");

    // MTRANSPOSE of ms1[e] = e
    for (int e = 0; e < N*N; e++) begin m1[e] = W'(e); mr[e] = W'((e % N) * N + e / N); end
    wr({BID, 12'h000}, pk(m1));
    run_busy(8'h05, 16, "mtranspose_busy");
    rd(12'h004, pk(mr), "mtranspose_result");

    // MSCALE by ms2[0][0] = 2
    for (int e = 0; e < N*N; e++) begin m2[e] = 16'd2; mr[e] = W'(2*e); end
    wr({BID, 12'h001}, pk(m2));
    run_busy(8'h06, 16, "mscale_busy");
    rd(12'h004, pk(mr), "mscale_result");

    // MSCALEIMM by imm = 3, with an SRC1 write attempted while busy
    for (int e = 0; e < N*N; e++) begin m2[e] = 16'd3; mr[e] = W'(3*e); end
    wr({BID, 12'h001}, pk(m2));
    wr({BID, 12'h002}, BUS_W'(8'h07));
    wr({BID, 12'h000}, {(N*N){16'hAAAA}});
    n = 0;
    while (Busy === 1'b1 && n < 200) begin n++; @(negedge Clk); end
    check("mscaleimm_finished", BUS_W'(Busy), '0);
    rd(12'h003, BUS_W'(3'b110), "busy_write_status");
    rd(12'h004, pk(mr), "mscaleimm_result");

    // Clear err with a valid op, then issue an invalid opcode.
    for (int e = 0; e < N*N; e++) mr[e] = W'(e+3);
    run_busy(8'h03, 16, "madd2_busy");
    rd(12'h003, BUS_W'(3'b010), "madd2_status");
    rd(12'h004, pk(mr), "madd2_result");
    wr({BID, 12'h002}, BUS_W'(8'h13));
    n = 0;
    repeat (4) begin
      if (Busy !== 1'b0) n++;
      @(negedge Clk);
    end
    check("invalid_op_busy_cycles", BUS_W'(n), '0);
    rd(12'h003, BUS_W'(3'b110), "invalid_op_status");

    // Reset in the middle of an MMULT
    wr({BID, 12'h002}, BUS_W'(8'h00));
    repeat (9) @(negedge Clk);
    nReset = 1'b0;
    @(negedge Clk);
    check("reset_abort_busy", BUS_W'(Busy), '0);
    nReset = 1'b1;
    rd(12'h003, '0, "reset_abort_status");
    rd(12'h004, '0, "reset_abort_result");

    repeat (3) @(negedge Clk);
    check("queue_drained", BUS_W'(q.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
